// File: rtl/cpu_queue_state.sv
// Per-queue ring-buffer state table (head, tail, host address) used by the FPGA-to-CPU DMA engine.
// Optional define HEAD_BYPASS_EN forwards CPU head writes into a live lookup and counts them.
module cpu_queue_state #(
    parameter int NB_QUEUES     = 1024,
    parameter int APP_IDX_WIDTH = 10,
    parameter int RB_AWIDTH     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dma_start,
    input  logic [APP_IDX_WIDTH-1:0] dma_queue,
    input  logic                     dma_done,
    input  logic [RB_AWIDTH-1:0]     out_tail,
    output logic                     queue_ready,
    output logic [RB_AWIDTH-1:0]     head,
    output logic [RB_AWIDTH-1:0]     tail,
    output logic [63:0]              kmem_addr,
    input  logic                     cfg_wr_en,
    input  logic [APP_IDX_WIDTH-1:0] cfg_wr_queue,
    input  logic [1:0]               cfg_wr_sel,
    input  logic [31:0]              cfg_wr_data,
    output logic [31:0]              head_fwd_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_READY
    } state_t;

    localparam logic [1:0] SEL_HEAD    = 2'd0;
    localparam logic [1:0] SEL_KMEM_LO = 2'd1;
    localparam logic [1:0] SEL_KMEM_HI = 2'd2;
    localparam logic [1:0] SEL_TAIL    = 2'd3;

    // kmem_addr is held as two 32-bit halves so a half-write needs no read-modify-write
    logic [RB_AWIDTH-1:0] head_mem    [NB_QUEUES];
    logic [RB_AWIDTH-1:0] tail_mem    [NB_QUEUES];
    logic [31:0]          kmem_lo_mem [NB_QUEUES];
    logic [31:0]          kmem_hi_mem [NB_QUEUES];

    logic [RB_AWIDTH-1:0] head_rd_q;
    logic [RB_AWIDTH-1:0] tail_rd_q;
    logic [63:0]          kmem_rd_q;

    state_t                   state_q,     state_d;
    logic [APP_IDX_WIDTH-1:0] cur_q_q,     cur_q_d;
    logic                     ready_q,     ready_d;
    logic [RB_AWIDTH-1:0]     head_q,      head_d;
    logic [RB_AWIDTH-1:0]     tail_q,      tail_d;
    logic [63:0]              kmem_q,      kmem_d;
    logic                     wb_en;
    logic                     cpu_tail_drop;

`ifdef HEAD_BYPASS_EN
    logic                 fwd_hit;
    logic                 byp_pend_q, byp_pend_d;
    logic [RB_AWIDTH-1:0] byp_val_q,  byp_val_d;
    logic [31:0]          fwd_cnt_q,  fwd_cnt_d;
`endif

    // Reset in the same cycle as dma_done aborts the writeback.
    assign wb_en         = (state_q == S_READY) && dma_done && !rst;
    assign cpu_tail_drop = wb_en && (cfg_wr_queue == cur_q_q);

    always_comb begin
        state_d = state_q;
        cur_q_d = cur_q_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        kmem_d  = kmem_q;

        case (state_q)
            S_IDLE: begin
                if (dma_start) begin
                    cur_q_d = dma_queue;
                    state_d = S_RD1;
                end
            end
            S_RD1: state_d = S_RD2;
            S_RD2: begin
                head_d  = head_rd_q;
                tail_d  = tail_rd_q;
                kmem_d  = kmem_rd_q;
                ready_d = 1'b1;
                state_d = S_READY;
            end
            S_READY: begin
                if (dma_done) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef HEAD_BYPASS_EN
        fwd_hit    = cfg_wr_en && (cfg_wr_sel == SEL_HEAD) &&
                     (cfg_wr_queue == cur_q_q) && (state_q != S_IDLE);
        // A write seen in RD1 misses the RAM read, so it is parked until RD2.
        byp_pend_d = (state_q == S_RD1) && fwd_hit;
        byp_val_d  = byp_pend_d ? cfg_wr_data[RB_AWIDTH-1:0] : byp_val_q;
        if (state_q == S_RD2 && byp_pend_q) begin
            head_d = byp_val_q;
        end
        if (fwd_hit && state_q != S_RD1) begin
            head_d = cfg_wr_data[RB_AWIDTH-1:0];
        end
        fwd_cnt_d  = fwd_cnt_q + 32'(fwd_hit);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q_q <= '0;
            ready_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            kmem_q  <= '0;
`ifdef HEAD_BYPASS_EN
            byp_pend_q <= 1'b0;
            byp_val_q  <= '0;
            fwd_cnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q_q <= cur_q_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            kmem_q  <= kmem_d;
`ifdef HEAD_BYPASS_EN
            byp_pend_q <= byp_pend_d;
            byp_val_q  <= byp_val_d;
            fwd_cnt_q  <= fwd_cnt_d;
`endif
        end
    end

    // NOTE: RAM arrays and their read registers carry no reset so they map onto block RAM;
    // software initialises every queue before use.
    always_ff @(posedge clk) begin
        if (cfg_wr_en) begin
            case (cfg_wr_sel)
                SEL_HEAD:    head_mem[cfg_wr_queue]    <= cfg_wr_data[RB_AWIDTH-1:0];
                SEL_KMEM_LO: kmem_lo_mem[cfg_wr_queue] <= cfg_wr_data;
                SEL_KMEM_HI: kmem_hi_mem[cfg_wr_queue] <= cfg_wr_data;
                SEL_TAIL: begin
                    if (!cpu_tail_drop) begin
                        tail_mem[cfg_wr_queue] <= cfg_wr_data[RB_AWIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
        if (wb_en) begin
            tail_mem[cur_q_q] <= out_tail;
        end
        // cur_q_q is the registered read address; data lands in the read registers for RD2.
        if (state_q == S_RD1) begin
            head_rd_q <= head_mem[cur_q_q];
            tail_rd_q <= tail_mem[cur_q_q];
            kmem_rd_q <= {kmem_hi_mem[cur_q_q], kmem_lo_mem[cur_q_q]};
        end
    end

    assign queue_ready = ready_q;
    assign head        = head_q;
    assign tail        = tail_q;
    assign kmem_addr   = kmem_q;
`ifdef HEAD_BYPASS_EN
    assign head_fwd_cnt = fwd_cnt_q;
`else
    assign head_fwd_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_queue_state.sv
// Directed bench for cpu_queue_state; expected values are hand-derived per scenario.
// Builds with or without HEAD_BYPASS_EN.
module tb_cpu_queue_state;

    localparam int QW = 10;
    localparam int RW = 10;
`ifdef HEAD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          dma_start;
    logic [QW-1:0] dma_queue;
    logic          dma_done;
    logic [RW-1:0] out_tail;
    logic          queue_ready;
    logic [RW-1:0] head;
    logic [RW-1:0] tail;
    logic [63:0]   kmem_addr;
    logic          cfg_wr_en;
    logic [QW-1:0] cfg_wr_queue;
    logic [1:0]    cfg_wr_sel;
    logic [31:0]   cfg_wr_data;
    logic [31:0]   head_fwd_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_queue_state #(.NB_QUEUES(1024), .APP_IDX_WIDTH(QW), .RB_AWIDTH(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .dma_start    (dma_start),
        .dma_queue    (dma_queue),
        .dma_done     (dma_done),
        .out_tail     (out_tail),
        .queue_ready  (queue_ready),
        .head         (head),
        .tail         (tail),
        .kmem_addr    (kmem_addr),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_queue (cfg_wr_queue),
        .cfg_wr_sel   (cfg_wr_sel),
        .cfg_wr_data  (cfg_wr_data),
        .head_fwd_cnt (head_fwd_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [QW-1:0] q, input logic [1:0] sel, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_wr_queue = q; cfg_wr_sel = sel; cfg_wr_data = d;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    // Leaves the DUT in READY (start cycle + RD1 + RD2).
    task automatic lookup(input logic [QW-1:0] q);
        dma_start = 1'b1; dma_queue = q;
        tick();
        dma_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic finish_dma(input logic [RW-1:0] t);
        dma_done = 1'b1; out_tail = t;
        tick();
        dma_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_checks++; if (queue_ready !== 1'b0) $display("FAIL reset_ready got %0b want 0", queue_ready); else n_pass++;
        n_checks++; if (head !== '0) $display("FAIL reset_head got %0d want 0", head); else n_pass++;
        n_checks++; if (tail !== '0) $display("FAIL reset_tail got %0d want 0", tail); else n_pass++;
        n_checks++; if (kmem_addr !== 64'd0) $display("FAIL reset_kmem got %h want 0", kmem_addr); else n_pass++;
        n_checks++; if (head_fwd_cnt !== 32'd0) $display("FAIL reset_cnt got %0d want 0", head_fwd_cnt); else n_pass++;
    endtask

    task automatic init_queues();
        cfg_wr(3, 2'd0, 32'd5);
        cfg_wr(3, 2'd3, 32'd2);
        cfg_wr(3, 2'd1, 32'h0000_2000);
        cfg_wr(3, 2'd2, 32'h0000_0001);
        cfg_wr(7, 2'd0, 32'd11);
        cfg_wr(7, 2'd3, 32'd13);
        cfg_wr(7, 2'd1, 32'h0000_0040);
        cfg_wr(7, 2'd2, 32'hdead_beef);
    endtask

    task automatic test_lookup();
        int bad;
        dma_start = 1'b1; dma_queue = 3;
        tick();
        dma_start = 1'b0;
        n_checks++; if (queue_ready !== 1'b0) $display("FAIL lookup_t1_ready got %0b want 0", queue_ready); else n_pass++;
        tick();
        n_checks++; if (queue_ready !== 1'b0) $display("FAIL lookup_t2_ready got %0b want 0", queue_ready); else n_pass++;
        tick();
        n_checks++; if (queue_ready !== 1'b1) $display("FAIL lookup_t3_ready got %0b want 1", queue_ready); else n_pass++;
        n_checks++; if (head !== 10'd5) $display("FAIL lookup_head got %0d want 5", head); else n_pass++;
        n_checks++; if (tail !== 10'd2) $display("FAIL lookup_tail got %0d want 2", tail); else n_pass++;
        n_checks++; if (kmem_addr !== 64'h1_0000_2000) $display("FAIL lookup_kmem got %h want 100002000", kmem_addr); else n_pass++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (queue_ready !== 1'b1 || head !== 10'd5 || tail !== 10'd2 || kmem_addr !== 64'h1_0000_2000) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL lookup_stable unstable_cycles %0d want 0", bad); else n_pass++;
    endtask

    task automatic test_done();
        finish_dma(9);
        n_checks++; if (queue_ready !== 1'b0) $display("FAIL done_ready got %0b want 0", queue_ready); else n_pass++;
        lookup(3);
        n_checks++; if (queue_ready !== 1'b1) $display("FAIL relookup_ready got %0b want 1", queue_ready); else n_pass++;
        n_checks++; if (tail !== 10'd9) $display("FAIL relookup_tail got %0d want 9", tail); else n_pass++;
    endtask

    task automatic test_ignored();
        dma_start = 1'b1; dma_queue = 7;
        tick();
        dma_start = 1'b0;
        tick();
        tick();
        n_checks++; if (queue_ready !== 1'b1) $display("FAIL ign_start_ready got %0b want 1", queue_ready); else n_pass++;
        n_checks++; if (head !== 10'd5) $display("FAIL ign_start_head got %0d want 5", head); else n_pass++;
        n_checks++; if (kmem_addr !== 64'h1_0000_2000) $display("FAIL ign_start_kmem got %h want 100002000", kmem_addr); else n_pass++;
        finish_dma(9);
        finish_dma(50);
        n_checks++; if (queue_ready !== 1'b0) $display("FAIL ign_done_ready got %0b want 0", queue_ready); else n_pass++;
        lookup(3);
        n_checks++; if (tail !== 10'd9) $display("FAIL ign_done_tail got %0d want 9", tail); else n_pass++;
    endtask

    task automatic test_head_write();
        logic [RW-1:0] exp_h;
        cfg_wr(7, 2'd0, 32'd12);
        n_checks++; if (head !== 10'd5) $display("FAIL hw_other_head got %0d want 5", head); else n_pass++;
        n_checks++; if (head_fwd_cnt !== 32'd0) $display("FAIL hw_other_cnt got %0d want 0", head_fwd_cnt); else n_pass++;
        cfg_wr(3, 2'd0, 32'd40);
        exp_h = BYP ? 10'd40 : 10'd5;
        n_checks++; if (head !== exp_h) $display("FAIL hw_ready_head got %0d want %0d", head, exp_h); else n_pass++;
        n_checks++; if (head_fwd_cnt !== 32'(BYP)) $display("FAIL hw_ready_cnt got %0d want %0d", head_fwd_cnt, BYP); else n_pass++;
        finish_dma(9);
        lookup(3);
        n_checks++; if (head !== 10'd40) $display("FAIL hw_next_head got %0d want 40", head); else n_pass++;
        finish_dma(9);
    endtask

    task automatic test_head_fwd_rd();
        logic [RW-1:0] exp_h;
        // head write during RD1
        dma_start = 1'b1; dma_queue = 3;
        tick();
        dma_start = 1'b0;
        cfg_wr(3, 2'd0, 32'd60);
        tick();
        exp_h = BYP ? 10'd60 : 10'd40;
        n_checks++; if (head !== exp_h) $display("FAIL fwd_rd1_head got %0d want %0d", head, exp_h); else n_pass++;
        n_checks++; if (head_fwd_cnt !== (BYP ? 32'd2 : 32'd0)) $display("FAIL fwd_rd1_cnt got %0d", head_fwd_cnt); else n_pass++;
        finish_dma(9);
        // head write during RD2 takes priority over the RAM data
        dma_start = 1'b1; dma_queue = 3;
        tick();
        dma_start = 1'b0;
        tick();
        cfg_wr(3, 2'd0, 32'd61);
        exp_h = BYP ? 10'd61 : 10'd60;
        n_checks++; if (queue_ready !== 1'b1) $display("FAIL fwd_rd2_ready got %0b want 1", queue_ready); else n_pass++;
        n_checks++; if (head !== exp_h) $display("FAIL fwd_rd2_head got %0d want %0d", head, exp_h); else n_pass++;
        n_checks++; if (head_fwd_cnt !== (BYP ? 32'd3 : 32'd0)) $display("FAIL fwd_rd2_cnt got %0d", head_fwd_cnt); else n_pass++;
        finish_dma(9);
    endtask

    task automatic test_collision();
        lookup(3);
        dma_done = 1'b1; out_tail = 7;
        cfg_wr_en = 1'b1; cfg_wr_queue = 3; cfg_wr_sel = 2'd3; cfg_wr_data = 32'd0;
        tick();
        dma_done = 1'b0; cfg_wr_en = 1'b0;
        n_checks++; if (queue_ready !== 1'b0) $display("FAIL coll_ready got %0b want 0", queue_ready); else n_pass++;
        lookup(3);
        n_checks++; if (tail !== 10'd7) $display("FAIL coll_tail got %0d want 7", tail); else n_pass++;
        n_checks++; if (head !== 10'd61) $display("FAIL coll_head got %0d want 61", head); else n_pass++;
        finish_dma(7);
    endtask

    task automatic test_cfg_visibility();
        // CPU write and dma_start in the same cycle: RD1 is one cycle later, so the write is seen.
        cfg_wr_en = 1'b1; cfg_wr_queue = 7; cfg_wr_sel = 2'd0; cfg_wr_data = 32'd100;
        dma_start = 1'b1; dma_queue = 7;
        tick();
        cfg_wr_en = 1'b0; dma_start = 1'b0;
        tick();
        tick();
        n_checks++; if (head !== 10'd100) $display("FAIL vis_head got %0d want 100", head); else n_pass++;
        n_checks++; if (tail !== 10'd13) $display("FAIL vis_tail got %0d want 13", tail); else n_pass++;
        n_checks++; if (kmem_addr !== 64'hdead_beef_0000_0040) $display("FAIL vis_kmem got %h want deadbeef00000040", kmem_addr); else n_pass++;
        finish_dma(13);
        cfg_wr(7, 2'd2, 32'h1234_5678);
        cfg_wr(7, 2'd3, 32'd21);
        lookup(7);
        n_checks++; if (kmem_addr !== 64'h1234_5678_0000_0040) $display("FAIL half_kmem got %h want 1234567800000040", kmem_addr); else n_pass++;
        n_checks++; if (tail !== 10'd21) $display("FAIL reinit_tail got %0d want 21", tail); else n_pass++;
        finish_dma(21);
    endtask

    task automatic test_reset_mid();
        dma_start = 1'b1; dma_queue = 3;
        tick();
        dma_start = 1'b0;
        tick();
        rst = 1'b1; dma_done = 1'b1; out_tail = 30;
        tick();
        n_checks++; if (queue_ready !== 1'b0) $display("FAIL rstmid_ready got %0b want 0", queue_ready); else n_pass++;
        n_checks++; if (tail !== '0) $display("FAIL rstmid_tail_out got %0d want 0", tail); else n_pass++;
        rst = 1'b0; dma_done = 1'b0;
        tick();
        lookup(3);
        n_checks++; if (queue_ready !== 1'b1) $display("FAIL rstmid_relookup_ready got %0b want 1", queue_ready); else n_pass++;
        n_checks++; if (tail !== 10'd7) $display("FAIL rstmid_relookup_tail got %0d want 7", tail); else n_pass++;
        n_checks++; if (head !== 10'd61) $display("FAIL rstmid_relookup_head got %0d want 61", head); else n_pass++;
        finish_dma(7);
    endtask

    initial begin
        rst = 1'b1; dma_start = 1'b0; dma_queue = '0; dma_done = 1'b0; out_tail = '0;
        cfg_wr_en = 1'b0; cfg_wr_queue = '0; cfg_wr_sel = '0; cfg_wr_data = '0;
        test_reset();
        init_queues();
        test_lookup();
        test_done();
        test_ignored();
        test_head_write();
        test_head_fwd_rd();
        test_collision();
        test_cfg_visibility();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
